// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             start_i;
   logic [4:0]       id_rs1_addr_i;
   logic [4:0]       id_rs2_addr_i;
   logic             id_uses_rs2_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rd_addr_i;
   logic             branch_taken_i;
   logic             mem_req_i;
   logic             pc_write_o;
   logic             if_id_write_o;
   logic             if_id_flush_o;
   logic             id_ex_hold_o;
   logic             id_ex_bubble_o;
   logic             ex_mem_hold_o;
   logic             mem_wb_bubble_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   logic [CNT_W-1:0] memwait_cnt_o;

   modport master (
      output start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i,
             ex_memread_i, ex_rd_addr_i, branch_taken_i, mem_req_i,
      input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_hold_o,
             id_ex_bubble_o, ex_mem_hold_o, mem_wb_bubble_o,
             stall_cnt_o, flush_cnt_o, memwait_cnt_o
   );

   modport slave (
      input  start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i,
             ex_memread_i, ex_rd_addr_i, branch_taken_i, mem_req_i,
      output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_hold_o,
             id_ex_bubble_o, ex_mem_hold_o, mem_wb_bubble_o,
             stall_cnt_o, flush_cnt_o, memwait_cnt_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, taken-branch flush,
// multi-cycle data-memory wait, plus saturating performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned CNT_W   = 32
) (
   input logic                    clk_i,
   input logic                    rst_n_i,
   pipeline_hazard_ctrl_if.slave  bus
);

   localparam int unsigned WCNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_LAST = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              mem_stall;
   logic              load_use;
   logic              freeze;
   logic              stall_inc, flush_inc, memwait_inc;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]  memwait_cnt_q, memwait_cnt_d;

   // Memory-wait FSM state and wait counter
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next state and memory stall; the FSM only advances while the pipeline runs
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.mem_req_i && (MEM_LAT > 1)) begin
               mem_stall = 1'b1;
               if (bus.start_i) begin
                  wcnt_d  = WCNT_W'(MEM_LAT - 2);
                  state_d = (MEM_LAT > 2) ? ST_WAIT : ST_LAST;
               end
            end
         end
         ST_WAIT: begin
            mem_stall = 1'b1;
            if (bus.start_i) begin
               wcnt_d = wcnt_q - WCNT_W'(1);
               if (wcnt_q == WCNT_W'(1)) begin
                  state_d = ST_LAST;
               end
            end
         end
         ST_LAST: begin
            // access completes this cycle; a new request is only seen back in IDLE
            if (bus.start_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // Load-use hazard between the load in EX and the consumer in ID (x0 never hazards)
   always_comb begin
      load_use = bus.ex_memread_i && (bus.ex_rd_addr_i != 5'd0) &&
                 ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) ||
                  (bus.id_uses_rs2_i && (bus.ex_rd_addr_i == bus.id_rs2_addr_i)));
   end

   // Prioritised pipeline controls: freeze > load-use > taken branch > run
   always_comb begin
      freeze              = !rst_n_i || !bus.start_i || mem_stall;
      bus.pc_write_o      = 1'b1;
      bus.if_id_write_o   = 1'b1;
      bus.if_id_flush_o   = 1'b0;
      bus.id_ex_hold_o    = 1'b0;
      bus.id_ex_bubble_o  = 1'b0;
      bus.ex_mem_hold_o   = 1'b0;
      bus.mem_wb_bubble_o = 1'b0;
      stall_inc           = 1'b0;
      if (freeze) begin
         bus.pc_write_o      = 1'b0;
         bus.if_id_write_o   = 1'b0;
         bus.id_ex_hold_o    = 1'b1;
         bus.ex_mem_hold_o   = 1'b1;
         bus.mem_wb_bubble_o = 1'b1;
      end else if (load_use) begin
         // a taken branch this cycle is dropped and re-resolves after the bubble
         bus.pc_write_o     = 1'b0;
         bus.if_id_write_o  = 1'b0;
         bus.id_ex_bubble_o = 1'b1;
         stall_inc          = 1'b1;
      end else if (bus.branch_taken_i) begin
         bus.if_id_flush_o = 1'b1;
      end
      flush_inc   = bus.if_id_flush_o;
      memwait_inc = bus.start_i && mem_stall;
   end

   // Saturating counter increments
   always_comb begin
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      memwait_cnt_d = memwait_cnt_q;
      if (stall_inc && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (memwait_inc && (memwait_cnt_q != '1)) begin
         memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
      end
   end

   // Performance counter registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         memwait_cnt_q <= '0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         memwait_cnt_q <= memwait_cnt_d;
      end
   end

   assign bus.stall_cnt_o   = stall_cnt_q;
   assign bus.flush_cnt_o   = flush_cnt_q;
   assign bus.memwait_cnt_o = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (MEM_LAT=3/CNT_W=32 and MEM_LAT=1/CNT_W=2)
// share stimulus and are checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       uses = 1'b0, memread = 1'b0, br = 1'b0, req = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
   pipeline_hazard_ctrl_if #(.CNT_W(2))  bus1 ();

   assign bus0.start_i = start;         assign bus1.start_i = start;
   assign bus0.id_rs1_addr_i = rs1;     assign bus1.id_rs1_addr_i = rs1;
   assign bus0.id_rs2_addr_i = rs2;     assign bus1.id_rs2_addr_i = rs2;
   assign bus0.id_uses_rs2_i = uses;    assign bus1.id_uses_rs2_i = uses;
   assign bus0.ex_memread_i = memread;  assign bus1.ex_memread_i = memread;
   assign bus0.ex_rd_addr_i = rd;       assign bus1.ex_rd_addr_i = rd;
   assign bus0.branch_taken_i = br;     assign bus1.branch_taken_i = br;
   assign bus0.mem_req_i = req;         assign bus1.mem_req_i = req;

   pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(32)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
   pipeline_hazard_ctrl #(.MEM_LAT(1), .CNT_W(2))  dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

   // ---------------- behavioural model ----------------
   int unsigned lat  [2] = '{3, 1};
   int unsigned cmax [2] = '{32'hFFFF_FFFF, 3};
   int unsigned m_left [2] = '{0, 0};   // stall cycles still owed after this access began
   bit          m_done [2] = '{0, 0};   // completion cycle of an access pending
   int unsigned m_stall[2] = '{0, 0};
   int unsigned m_flush[2] = '{0, 0};
   int unsigned m_mw   [2] = '{0, 0};

   function automatic bit lu_now();
      return memread && (rd != 5'd0) && ((rd == rs1) || (uses && (rd == rs2)));
   endfunction

   function automatic bit m_memstall(int k);
      return (m_left[k] > 0) || (!m_done[k] && req && (lat[k] > 1));
   endfunction

   // {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble}
   function automatic logic [6:0] exp_ctrl(int k);
      if (!rst_n || !start || m_memstall(k)) return 7'b0001011;
      if (lu_now())                          return 7'b0000100;
      if (br)                                return 7'b1110000;
      return 7'b1100000;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_done[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_mw[k] = 0;
         end
      end else if (start) begin
         for (int k = 0; k < 2; k++) begin
            if (m_memstall(k)) begin
               if (m_mw[k] != cmax[k]) m_mw[k]++;
            end else if (lu_now()) begin
               if (m_stall[k] != cmax[k]) m_stall[k]++;
            end else if (br) begin
               if (m_flush[k] != cmax[k]) m_flush[k]++;
            end
            if (m_left[k] > 0) begin
               m_left[k]--;
               if (m_left[k] == 0) m_done[k] = 1'b1;
            end else if (m_done[k]) begin
               m_done[k] = 1'b0;
            end else if (req && (lat[k] > 1)) begin
               m_left[k] = lat[k] - 2;
               m_done[k] = (lat[k] == 2);
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] ctrl0();
      return {bus0.pc_write_o, bus0.if_id_write_o, bus0.if_id_flush_o, bus0.id_ex_hold_o,
              bus0.id_ex_bubble_o, bus0.ex_mem_hold_o, bus0.mem_wb_bubble_o};
   endfunction

   function automatic logic [6:0] ctrl1();
      return {bus1.pc_write_o, bus1.if_id_write_o, bus1.if_id_flush_o, bus1.id_ex_hold_o,
              bus1.id_ex_bubble_o, bus1.ex_mem_hold_o, bus1.mem_wb_bubble_o};
   endfunction

   task automatic model_check();
      chk("ctrl0",    32'(ctrl0()),           32'(exp_ctrl(0)));
      chk("stall0",   bus0.stall_cnt_o,       m_stall[0]);
      chk("flush0",   bus0.flush_cnt_o,       m_flush[0]);
      chk("memwait0", bus0.memwait_cnt_o,     m_mw[0]);
      chk("ctrl1",    32'(ctrl1()),           32'(exp_ctrl(1)));
      chk("stall1",   32'(bus1.stall_cnt_o),  m_stall[1]);
      chk("flush1",   32'(bus1.flush_cnt_o),  m_flush[1]);
      chk("memwait1", 32'(bus1.memwait_cnt_o), m_mw[1]);
   endtask

   task automatic drive(input logic s, input logic [4:0] a1, input logic [4:0] a2, input logic u,
                        input logic mr, input logic [4:0] d, input logic b, input logic q);
      start = s; rs1 = a1; rs2 = a2; uses = u; memread = mr; rd = d; br = b; req = q;
   endtask

   task automatic to_neg();
      @(negedge clk);
      model_check();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      to_neg();
      chk("rst_pc_write",  32'(bus0.pc_write_o), 0);
      chk("rst_ifid_wr",   32'(bus0.if_id_write_o), 0);
      chk("rst_idex_hold", 32'(bus0.id_ex_hold_o), 1);
      chk("rst_exmem",     32'(bus0.ex_mem_hold_o), 1);
      chk("rst_memwb",     32'(bus0.mem_wb_bubble_o), 1);
      chk("rst_stall",     bus0.stall_cnt_o, 0);
      to_pos();
      rst_n = 1'b1;

      // load x5 in EX, ID reads rs1=5
      drive(1, 5, 0, 0, 1, 5, 0, 0); to_neg();
      chk("lu_pc_write", 32'(bus0.pc_write_o), 0);
      chk("lu_bubble",   32'(bus0.id_ex_bubble_o), 1);
      to_pos();
      // load into x0: no hazard
      drive(1, 0, 0, 0, 1, 0, 0, 0); to_neg();
      chk("lu_stall_cnt", bus0.stall_cnt_o, 1);
      chk("x0_pc_write",  32'(bus0.pc_write_o), 1);
      to_pos();
      // rs2 match but rs2 unused: no hazard
      drive(1, 3, 7, 0, 1, 7, 0, 0); to_neg();
      chk("rs2_unused_pc", 32'(bus0.pc_write_o), 1);
      to_pos();
      // taken branch, no hazard
      drive(1, 3, 0, 0, 0, 0, 1, 0); to_neg();
      chk("br_flush", 32'(bus0.if_id_flush_o), 1);
      to_pos();
      // taken branch with load-use: suppressed
      drive(1, 9, 0, 0, 1, 9, 1, 0); to_neg();
      chk("br_flush_cnt",  bus0.flush_cnt_o, 1);
      chk("br_lu_flush",   32'(bus0.if_id_flush_o), 0);
      chk("br_lu_bubble",  32'(bus0.id_ex_bubble_o), 1);
      to_pos();
      // memory access held high: stall cycles 0,1, release 2
      drive(1, 0, 0, 0, 0, 0, 0, 1); to_neg();
      chk("br_lu_flush_cnt", bus0.flush_cnt_o, 1);
      chk("br_lu_stall_cnt", bus0.stall_cnt_o, 2);
      chk("mem_c0_hold",     32'(bus0.ex_mem_hold_o), 1);
      chk("lat1_no_stall",   32'(bus1.ex_mem_hold_o), 0);
      to_pos(); to_neg();
      chk("mem_c1_hold", 32'(bus0.ex_mem_hold_o), 1);
      to_pos(); to_neg();
      chk("mem_c2_hold", 32'(bus0.ex_mem_hold_o), 0);
      chk("mem_c2_pc",   32'(bus0.pc_write_o), 1);
      to_pos(); to_neg();
      chk("mem_wait_cnt", bus0.memwait_cnt_o, 2);
      chk("mem_c3_hold",  32'(bus0.ex_mem_hold_o), 1);
      to_pos();
      // load-use during the memory stall: freeze wins
      drive(1, 4, 0, 0, 1, 4, 0, 0); to_neg();
      chk("frz_lu_hold",   32'(bus0.ex_mem_hold_o), 1);
      chk("frz_lu_bubble", 32'(bus0.id_ex_bubble_o), 0);
      to_pos(); to_neg();
      chk("frz_lu_stall_cnt", bus0.stall_cnt_o, 2);
      chk("mem_wait_cnt2",    bus0.memwait_cnt_o, 4);
      chk("post_frz_bubble",  32'(bus0.id_ex_bubble_o), 1);
      to_pos();
      // start low: frozen, counters held
      drive(0, 4, 0, 0, 1, 4, 1, 1); to_neg();
      chk("stop_stall_cnt", bus0.stall_cnt_o, 3);
      chk("stop_pc",        32'(bus0.pc_write_o), 0);
      to_pos(); to_neg();
      chk("stop_hold_cnt", bus0.stall_cnt_o, 3);
      chk("stop_flush",    bus0.flush_cnt_o, 1);
      chk("sat_stall1",    32'(bus1.stall_cnt_o), 3);
      to_pos();
      // enter WAIT, then reset asynchronously mid-wait
      drive(1, 0, 0, 0, 0, 0, 0, 1); to_neg();
      to_pos();
      drive(1, 0, 0, 0, 0, 0, 0, 0); to_neg();
      chk("wait_hold", 32'(bus0.ex_mem_hold_o), 1);
      #1 rst_n = 1'b0;
      #1;
      model_check();
      chk("arst_stall",   bus0.stall_cnt_o, 0);
      chk("arst_memwait", bus0.memwait_cnt_o, 0);
      chk("arst_memwb",   32'(bus0.mem_wb_bubble_o), 1);
      to_pos();
      rst_n = 1'b1;
      to_neg();
      chk("post_rst_idle_pc", 32'(bus0.pc_write_o), 1);
      to_pos();

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
         to_neg();
         to_pos();
         rst_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
